// File: rtl/instruction_encoder.sv
// Instruction encoder: range-checks field-level instructions from the program
// loader, packs them into 16-bit words, buffers them in a small FIFO and writes
// them sequentially into instruction memory starting at a programmable base.
module instruction_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_ra,
    input  logic [2:0]        in_rb,
    input  logic [2:0]        in_rc,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   wr_count
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] E_OPCODE = 2'd1;
    localparam logic [1:0] E_IMM    = 2'd2;
    localparam logic [1:0] E_REG    = 2'd3;

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W:0]  FIFO_FULL = (PTR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [15:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_idx;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W:0]    fifo_cnt;

    logic signed [15:0] imm_s;
    logic [15:0]        enc_word;
    logic [1:0]         enc_code;
    logic               enc_legal;

    logic fifo_empty, fifo_full;
    logic slot_free, pop, accept, push, bypass, fifo_wr, load_out, wr_done;
    logic [15:0] out_word;

    assign imm_s = in_imm;

    // Pack the instruction fields and classify the first rule it violates.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        enc_word = 16'h0000;
        enc_code = 2'd0;
        case (in_opcode)
            4'h2, 4'h4, 4'h6, 4'h7: begin
                enc_word = {in_opcode, in_ra, in_rb, in_rc, 3'b000};
            end
            4'h0, 4'h1, 4'h5: begin
                enc_word = {in_opcode, in_ra, in_rb[1:0], in_imm[6:0]};
                if (imm_s < -16'sd64 || imm_s > 16'sd63)
                    enc_code = E_IMM;
                else if (in_rb > 3'd3)
                    enc_code = E_REG;
            end
            4'h3, 4'h8, 4'h9: begin
                enc_word = {in_opcode, in_ra, 3'b000, in_imm[5:0]};
                if (imm_s < -16'sd32 || imm_s > 16'sd31 || imm_s == 16'sd0)
                    enc_code = E_IMM;
            end
            4'hA, 4'hB: begin
                enc_word = {in_opcode, in_ra, in_imm[8:0]};
                if (imm_s < -16'sd256 || imm_s > 16'sd255)
                    enc_code = E_IMM;
            end
            default: enc_code = E_OPCODE;
        endcase
    end

    assign enc_legal  = (enc_code == 2'd0);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);

    // The output register is free when it holds nothing or its write completes now.
    assign slot_free = !imem_we || imem_ready;
    assign wr_done   = imem_we && imem_ready;
    assign pop       = slot_free && !fifo_empty;
    assign in_ready  = (state == S_LOAD) && (!fifo_full || pop);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    // An empty FIFO with a free output slot forwards the word straight out.
    assign bypass    = push && slot_free && fifo_empty;
    assign fifo_wr   = push && !bypass;
    assign load_out  = pop || bypass;
    assign out_word  = fifo_empty ? enc_word : fifo_mem[rd_idx];

    assign busy = (state == S_LOAD) || (state == S_FLUSH);
    assign done = (state == S_DONE);

    // Sequence IDLE -> LOAD -> FLUSH -> DONE; start restarts from any state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (start) begin
            state <= S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (accept && in_last) state <= S_FLUSH;
                S_FLUSH: if (fifo_empty && !imem_we) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= state;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; emptiness is tracked by fifo_cnt alone.
        if (fifo_wr) fifo_mem[wr_idx] <= enc_word;
    end

    // FIFO pointers and occupancy, flushed by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx   <= '0;
            wr_idx   <= '0;
            fifo_cnt <= '0;
        end else if (start) begin
            rd_idx   <= '0;
            wr_idx   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_idx <= wr_idx + 1'b1;
            if (pop)     rd_idx <= rd_idx + 1'b1;
            if (fifo_wr && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!fifo_wr && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    // Memory write port: hold the request until accepted, then advance address/count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            wr_count   <= '0;
        end else if (start) begin
            imem_we    <= 1'b0;
            imem_addr  <= base_addr;
            imem_wdata <= '0;
            wr_count   <= '0;
        end else begin
            if (wr_done) begin
                imem_addr <= imem_addr + 1'b1;
                if (wr_count != COUNT_MAX) wr_count <= wr_count + 1'b1;
            end
            if (load_out) begin
                imem_we    <= 1'b1;
                imem_wdata <= out_word;
            end else if (wr_done) begin
                imem_we <= 1'b0;
            end
        end
    end

    // Sticky error flag; only the first illegal instruction's code is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (start) begin
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (accept && !enc_legal && !err) begin
            err      <= 1'b1;
            err_code <= enc_code;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder with hand-computed words.
module tb_instruction_encoder;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [3:0]        in_opcode = '0;
    logic [2:0]        in_ra = '0;
    logic [2:0]        in_rb = '0;
    logic [2:0]        in_rc = '0;
    logic [15:0]       in_imm = '0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              imem_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   wr_count;

    instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_opcode(in_opcode), .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy),
        .done(done), .err(err), .err_code(err_code), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
        int                cyc;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  done_seen = 0;
    int  total = 0;
    int  bad = 0;

    // Record completed memory writes and done pulses away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (done) done_seen <= done_seen + 1;
        if (rst_n && imem_we && imem_ready) wq.push_back('{imem_addr, imem_wdata, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        base_addr = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wq.delete();
    endtask

    task automatic send(input string tag, input logic [3:0] op, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [2:0] rc,
                        input logic [15:0] imm, input logic last);
        logic ok;
        in_valid = 1'b1; in_opcode = op; in_ra = ra; in_rb = rb; in_rc = rc;
        in_imm = imm; in_last = last;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        check({tag, "_accept"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_cnt);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_wr_count"}, 32'(wr_count), 32'(exp_cnt));
        tick();
    endtask

    task automatic check_wr(input string tag, input int idx,
                            input logic [ADDR_W-1:0] a, input logic [15:0] d);
        if (idx < wq.size()) begin
            check({tag, "_addr"}, 32'(wq[idx].addr), 32'(a));
            check({tag, "_data"}, 32'(wq[idx].data), 32'(d));
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_err_code"}, 32'(err_code), 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin : main
        int d0;
        logic [15:0] stall_d [6];
        stall_d = '{16'h2298, 16'h44E0, 16'h6E08, 16'h71F8, 16'h1DC0, 16'h881F};

        // Reset values
        #3;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;
        tick();

        // Single add
        imem_ready = 1'b1;
        d0 = done_seen;
        do_start(8'h10);
        send("add", 4'h2, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1);
        wait_done("t1", 1);
        check("t1_n_writes", 32'(wq.size()), 32'd1);
        check_wr("t1_w0", 0, 8'h10, 16'h2298);
        @(negedge clk);
        check("t1_done_low", 32'(done), 32'd0);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_done_pulses", 32'(done_seen - d0), 32'd1);
        // in_valid in IDLE is ignored
        in_valid = 1'b1; in_opcode = 4'h2;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check("idle_no_write", 32'(wq.size()), 32'd1);

        // lw / addi / beqz back-to-back
        do_start(8'h10);
        send("lw", 4'h0, 3'd5, 3'd2, 3'd0, 16'd4, 1'b0);
        send("addi", 4'h3, 3'd3, 3'd0, 3'd0, 16'hFFFF, 1'b0);
        send("beqz", 4'hA, 3'd1, 3'd0, 3'd0, 16'hFFFE, 1'b1);
        wait_done("t2", 3);
        check("t2_n_writes", 32'(wq.size()), 32'd3);
        check_wr("t2_w0", 0, 8'h10, 16'h0B04);
        check_wr("t2_w1", 1, 8'h11, 16'h363F);
        check_wr("t2_w2", 2, 8'h12, 16'hA3FE);
        if (wq.size() == 3) check("t2_b2b", 32'(wq[2].cyc - wq[0].cyc), 32'd2);

        // Illegal instructions: first error kept
        do_start(8'h20);
        send("addi0", 4'h3, 3'd1, 3'd0, 3'd0, 16'h0000, 1'b0);
        send("opD", 4'hD, 3'd1, 3'd0, 3'd0, 16'h0000, 1'b1);
        wait_done("t3", 0);
        check("t3_n_writes", 32'(wq.size()), 32'd0);
        check("t3_err", 32'(err), 32'd1);
        check("t3_err_code", 32'(err_code), 32'd2);

        // Bad register first, then out-of-range branch, then a legal word
        do_start(8'h40);
        check("t4_err_cleared", 32'(err), 32'd0);
        send("lw_rb4", 4'h0, 3'd1, 3'd4, 3'd0, 16'd0, 1'b0);
        send("beqz_big", 4'hA, 3'd1, 3'd0, 3'd0, 16'hFEFF, 1'b0);
        send("add_ok", 4'h2, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1);
        wait_done("t4", 1);
        check("t4_err_code", 32'(err_code), 32'd3);
        check_wr("t4_w0", 0, 8'h40, 16'h2298);

        // Back-pressure: DEPTH+1 accepted while memory stalls
        imem_ready = 1'b0;
        do_start(8'h30);
        send("s0", 4'h2, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b0);
        send("s1", 4'h4, 3'd2, 3'd3, 3'd4, 16'h0000, 1'b0);
        send("s2", 4'h6, 3'd7, 3'd0, 3'd1, 16'h0000, 1'b0);
        send("s3", 4'h7, 3'd0, 3'd7, 3'd7, 16'h0000, 1'b0);
        send("s4", 4'h1, 3'd6, 3'd3, 3'd0, 16'hFFC0, 1'b0);
        in_valid = 1'b1; in_opcode = 4'h8; in_ra = 3'd4; in_imm = 16'd31; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_we", 32'(imem_we), 32'd1);
            check("stall_addr", 32'(imem_addr), 32'h30);
            check("stall_data", 32'(imem_wdata), 32'h2298);
        end
        tick();
        imem_ready = 1'b1;
        send("s5", 4'h8, 3'd4, 3'd0, 3'd0, 16'd31, 1'b1);
        wait_done("t5", 6);
        check("t5_n_writes", 32'(wq.size()), 32'd6);
        for (int k = 0; k < 6; k++) check_wr("t5_w", k, 8'(8'h30 + k), stall_d[k]);

        // Address wrap
        do_start(8'hFE);
        send("andi", 4'h5, 3'd1, 3'd3, 3'd0, 16'd63, 1'b0);
        send("sll", 4'h9, 3'd2, 3'd0, 3'd0, 16'hFFE0, 1'b0);
        send("bneqz", 4'hB, 3'd3, 3'd0, 3'd0, 16'd255, 1'b1);
        wait_done("t6", 3);
        check_wr("t6_w0", 0, 8'hFE, 16'h53BF);
        check_wr("t6_w1", 1, 8'hFF, 16'h9420);
        check_wr("t6_w2", 2, 8'h00, 16'hB6FF);

        // Asynchronous reset in FLUSH
        imem_ready = 1'b0;
        do_start(8'h60);
        send("r_add", 4'h2, 3'd1, 3'd2, 3'd3, 16'h0000, 1'b1);
        @(negedge clk);
        check("t7_busy", 32'(busy), 32'd1);
        check("t7_we", 32'(imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("t7_async");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        imem_ready = 1'b1;
        do_start(8'h50);
        send("r_lw", 4'h0, 3'd5, 3'd2, 3'd0, 16'd4, 1'b1);
        wait_done("t7", 1);
        check("t7_n_writes", 32'(wq.size()), 32'd1);
        check_wr("t7_w0", 0, 8'h50, 16'h0B04);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Encoder for the core's 16-bit, 4-bit-opcode ISA: the inverse of the instruction decoder.
- Accepts field-level instructions (opcode, registers, signed immediate) from the boot/debug program loader over a valid/ready stream.
- Range-checks each instruction and packs it into a 16-bit word.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from a programmable base address.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 4, encoded-word FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; loads base address, clears count/err, enters LOAD
base_addr  in  ADDR_W  first write address, sampled on start
in_valid  in  1  field-level instruction valid
in_ready  out  1  encoder can accept; handshake on in_valid&in_ready
in_last  in  1  qualifies final instruction of program
in_opcode  in  4  opcode (0 lw,1 sw,2 add,3 addi,4 and,5 andi,6 or,7 xor,8 srai,9 sll,A beqz,B bneqz)
in_ra  in  3  rd / rs2(sw) / rs1(beqz,bneqz)
in_rb  in  3  rs1 (R-type and I7 base)
in_rc  in  3  rs2 (R-type)
in_imm  in  16  signed two's-complement immediate/offset
imem_we  out  1  instruction-memory write request
imem_addr  out  ADDR_W  write address
imem_wdata  out  16  encoded word
imem_ready  in  1  memory accepts write when imem_we&imem_ready
busy  out  1  state is LOAD or FLUSH
done  out  1  1-cycle pulse after last word written
err  out  1  sticky illegal-instruction flag
err_code  out  2  first error: 1 bad opcode, 2 imm out of range, 3 bad register field
wr_count  out  ADDR_W+1  words written since start

Behaviour:
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_code=0, wr_count=0. FIFO is emptied and state=IDLE.
- Encodings (bit 15 on the left):
  - R (2,4,6,7): op[15:12] ra[11:9] rb[8:6] rc[5:3] 000.
  - I7 (0,1,5): op ra[11:9] rb[1:0]@[8:7] imm[6:0]. rb must be <=3, else code 3. imm must be in -64..63.
  - CI (3,8,9): op ra[11:9] 000 imm[5:0]. imm must be in -32..31 and nonzero.
  - B (A,B): op ra[11:9] imm[8:0]. imm must be in -256..255.
  - Opcode C-F is illegal.
- FSM states and transitions:
  - IDLE: start -> LOAD.
  - LOAD: in_ready = FIFO not full. Accepting with in_last -> FLUSH.
  - FLUSH: in_ready=0. When the FIFO is empty and no write is pending -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start in LOAD/FLUSH/DONE restarts: FIFO flushed, pending write dropped, counters reloaded.
- Illegal instruction: consumed (handshake completes) but not pushed. err is set and err_code is latched on the first error only. in_last on an illegal instruction still moves to FLUSH.
- Latency: word accepted in cycle N is visible as imem_we/imem_wdata no earlier than N+1.
- Memory write handshake:
  - imem_we, imem_addr and imem_wdata are held stable until imem_ready.
  - On each completed write: imem_addr increments (wraps modulo 2^ADDR_W) and wr_count increments (saturates at 2^ADDR_W).
  - With imem_ready held high, throughput is 1 word/cycle.
- FIFO boundaries:
  - Simultaneous push and pop when full is allowed; in_ready stays 1.
  - Push into empty FIFO with no write pending: the word is output next cycle.
- Asynchronous reset mid-operation aborts everything immediately. A partially loaded program is not rolled back.
- in_valid outside LOAD is ignored.

Test Plan:
- start base=0x10; add ra=1 rb=2 rc=3 last=1, imem_ready=1 -> write 0x2298 at 0x10; done pulse; wr_count=1.
- lw ra=5 rb=2 imm=4; addi ra=3 imm=-1; beqz ra=1 imm=-2 last -> writes 0x0B04 @0x10, 0x363F @0x11, 0xA3FE @0x12, back-to-back.
- addi imm=0, then opcode 0xD -> both consumed, nothing written, err=1, err_code=2 (first error kept).
- imem_ready=0 with DEPTH+1 instructions offered -> in_ready=0 after DEPTH accepted plus one pending. Releasing imem_ready drains all in order, with data stable while stalled.
- base=0xFE, ADDR_W=8, 3 instructions -> addresses 0xFE, 0xFF, 0x00; wr_count=3.
- rst_n low mid-FLUSH -> all outputs at reset values asynchronously; start afterwards loads cleanly.
